// File: rtl/spin_anim_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// spin_anim_ctrl_pkg
//   Shared definitions for the HEX0 segment-ring spinner: sequencer state
//   encoding, ring geometry, the twelve active-low segment patterns and a
//   ring-advance helper.
// ----------------------------------------------------------------------------
package spin_anim_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] POS_FIRST = 4'd0;
    localparam logic [3:0] POS_LAST  = 4'd11;

    // Bit i drives segment a..g, 0 = lit.
    localparam logic [6:0] SEG_A   = 7'b1111110;
    localparam logic [6:0] SEG_AB  = 7'b1111100;
    localparam logic [6:0] SEG_B   = 7'b1111101;
    localparam logic [6:0] SEG_BC  = 7'b1111001;
    localparam logic [6:0] SEG_C   = 7'b1111011;
    localparam logic [6:0] SEG_CD  = 7'b1110011;
    localparam logic [6:0] SEG_D   = 7'b1110111;
    localparam logic [6:0] SEG_DE  = 7'b1100111;
    localparam logic [6:0] SEG_E   = 7'b1101111;
    localparam logic [6:0] SEG_EF  = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1011111;
    localparam logic [6:0] SEG_FA  = 7'b1011110;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // One step around the ring; dir 0 = clockwise, 1 = counter-clockwise.
    function automatic logic [3:0] next_pos(input logic [3:0] p, input logic dir);
        if (!dir) return (p == POS_LAST)  ? POS_FIRST : p + 4'd1;
        else      return (p == POS_FIRST) ? POS_LAST  : p - 4'd1;
    endfunction

    // True when the step taken from p crosses the 11/0 seam.
    function automatic logic is_wrap(input logic [3:0] p, input logic dir);
        return dir ? (p == POS_FIRST) : (p == POS_LAST);
    endfunction

endpackage

// File: rtl/spin_anim_ctrl_seg_decode.sv
// ----------------------------------------------------------------------------
// spin_anim_ctrl_seg_decode
//   Combinational ring-position to active-low 7-segment pattern.
//   pos_i  in  4  ring position 0..11 (anything above 11 blanks the digit)
//   seg_o  out 7  segment pattern, bit i = segment a..g, 0 = lit
// ----------------------------------------------------------------------------
module spin_anim_ctrl_seg_decode
    import spin_anim_ctrl_pkg::*;
(
    input  logic [3:0] pos_i,
    output logic [6:0] seg_o
);

    always_comb begin
        case (pos_i)
            4'd0:    seg_o = SEG_A;
            4'd1:    seg_o = SEG_AB;
            4'd2:    seg_o = SEG_B;
            4'd3:    seg_o = SEG_BC;
            4'd4:    seg_o = SEG_C;
            4'd5:    seg_o = SEG_CD;
            4'd6:    seg_o = SEG_D;
            4'd7:    seg_o = SEG_DE;
            4'd8:    seg_o = SEG_E;
            4'd9:    seg_o = SEG_EF;
            4'd10:   seg_o = SEG_F;
            4'd11:   seg_o = SEG_FA;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/spin_anim_ctrl.sv
// ----------------------------------------------------------------------------
// spin_anim_ctrl
//   Sequencer for the single-digit segment-ring spinner on HEX0. A CLOCK_50
//   tick-enable prescaler paces a per-position dwell counter; the ring
//   position advances cw/ccw under run/pause/step control.
//   CLOCK_50 in  1  system clock, rising edge
//   reset    in  1  synchronous, active-high
//   start    in  1  pulse: IDLE -> RUN
//   stop     in  1  pulse: back to IDLE, pos <- 0
//   hold     in  1  level: pause while high
//   step     in  1  pulse: single advance while paused
//   dir      in  1  0 = clockwise, 1 = counter-clockwise
//   speed    in  2  tick period = CLK_DIV >> speed
//   HEX0     out 7  active-low segment drive
//   pos      out 4  ring position 0..11
//   busy     out 1  state != IDLE
//   lap_done out 1  one-cycle pulse on the 11/0 wrap
// ----------------------------------------------------------------------------
module spin_anim_ctrl
    import spin_anim_ctrl_pkg::*;
#(
    parameter int CLK_DIV      = 2500000,
    parameter int DWELL_SINGLE = 10,
    parameter int DWELL_PAIR   = 5
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       hold,
    input  logic       step,
    input  logic       dir,
    input  logic [1:0] speed,
    output logic [6:0] HEX0,
    output logic [3:0] pos,
    output logic       busy,
    output logic       lap_done
);

    localparam int CW        = $clog2(CLK_DIV);
    localparam int DMAX      = (DWELL_SINGLE > DWELL_PAIR) ? DWELL_SINGLE : DWELL_PAIR;
    localparam int DW        = (DMAX > 1) ? $clog2(DMAX) : 1;
    localparam logic [CW:0] DIV_FULL = (CW + 1)'(CLK_DIV);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]    pos_q,   pos_d;
    logic [6:0]    hex_q,   hex_d;
    logic          lap_q,   lap_d;

    logic [CW:0]   period;
    logic          tick;
    logic [DW-1:0] dwell_last;
    logic          advance;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: reset is sampled on the clock edge, so it lives inside the
    // clocked branch rather than the sensitivity list.
    always_ff @(posedge CLOCK_50) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state (stop > start > hold)
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (!stop && start) state_d = ST_RUN;
            ST_RUN:   if (stop)           state_d = ST_IDLE;
                      else if (hold)      state_d = ST_PAUSE;
            ST_PAUSE: if (stop)           state_d = ST_IDLE;
                      else if (!hold)     state_d = ST_RUN;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Prescaler, dwell and position datapath
    // ------------------------------------------------------------------
    // A '>=' compare rather than '==' lets a mid-count speed-up fire on the
    // next cycle instead of waiting for the counter to roll over.
    assign period     = DIV_FULL >> speed;
    assign tick       = ({1'b0, cnt_q} >= (period - (CW + 1)'(1)));
    assign dwell_last = pos_q[0] ? DW'(DWELL_PAIR - 1) : DW'(DWELL_SINGLE - 1);

    // NOTE: every signal gets a default up front so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        pos_d   = pos_q;
        advance = 1'b0;
        unique case (state_q)
            ST_IDLE: cnt_d = '0;
            ST_RUN: begin
                if (stop) begin
                    cnt_d   = '0;
                    dwell_d = '0;
                    pos_d   = POS_FIRST;
                end else if (tick) begin
                    // A tick coinciding with hold rising is still honoured.
                    cnt_d = '0;
                    if (dwell_q == dwell_last) begin
                        advance = 1'b1;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + DW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    cnt_d   = '0;
                    dwell_d = '0;
                    pos_d   = POS_FIRST;
                end else if (hold && step) begin
                    advance = 1'b1;
                    dwell_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                dwell_d = '0;
                pos_d   = POS_FIRST;
            end
        endcase
        if (advance) pos_d = next_pos(pos_q, dir);
        lap_d = advance && is_wrap(pos_q, dir);
    end

    // HEX0 is registered from the next position so it changes on the same
    // edge as pos.
    spin_anim_ctrl_seg_decode u_seg_decode (
        .pos_i (pos_d),
        .seg_o (hex_d)
    );

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cnt_q   <= '0;
            dwell_q <= '0;
            pos_q   <= POS_FIRST;
            hex_q   <= SEG_A;
            lap_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            pos_q   <= pos_d;
            hex_q   <= hex_d;
            lap_q   <= lap_d;
        end
    end

    assign HEX0     = hex_q;
    assign pos      = pos_q;
    assign lap_done = lap_q;

endmodule
